// File: rtl/pls_fixed_divider.sv
// Fixed-point AXI-Stream divider: result = trunc(a * 2^RES_SHIFT / b), signed a, unsigned b.
// Radix-2 restoring core, one quotient bit per cycle, fixed data-independent latency.
module pls_fixed_divider #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned RES_SHIFT = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [DATA_SIZE-1:0] div_a_tdata,
  input  logic                 div_a_tvalid,
  output logic                 div_a_tready,
  input  logic [DATA_SIZE-1:0] div_b_tdata,
  input  logic                 div_b_tvalid,
  output logic                 div_b_tready,
  output logic [DATA_SIZE-1:0] div_result_tdata,
  output logic [1:0]           div_result_tuser,
  output logic                 div_result_tvalid,
  input  logic                 div_result_tready,
  output logic                 busy
);

  localparam int unsigned Iter = DATA_SIZE + RES_SHIFT;
  localparam int unsigned CntW = $clog2(Iter);
  localparam logic [DATA_SIZE-1:0] MaxPos = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] MinNeg = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StOut} state_e;

  state_e               state_q;
  logic                 a_rdy_q, b_rdy_q, a_held_q, b_held_q, busy_q, valid_q;
  logic [DATA_SIZE-1:0] a_q, b_q, rem_q, data_q;
  logic [1:0]           user_q;
  logic [Iter-1:0]      num_q;
  logic [CntW-1:0]      cnt_q;

  logic                 a_take, b_take;
  logic [DATA_SIZE-1:0] a_mag;
  logic [DATA_SIZE:0]   trial;
  logic                 trial_ge;
  logic [DATA_SIZE-1:0] trial_diff, rem_next;
  logic                 neg, pos_ovf, neg_ovf;
  logic [DATA_SIZE-1:0] fix_data;
  logic [1:0]           fix_user;

  assign a_take = div_a_tvalid & a_rdy_q;
  assign b_take = div_b_tvalid & b_rdy_q;

  always_comb begin
    // Unsigned DATA_SIZE-bit magnitude is exact even for the most-negative dividend.
    a_mag      = div_a_tdata[DATA_SIZE-1] ? -div_a_tdata : div_a_tdata;
    trial      = {rem_q, num_q[Iter-1]};
    trial_ge   = trial >= {1'b0, b_q};
    // Remainder stays below b, so the modular difference is exact when it is kept.
    trial_diff = trial[DATA_SIZE-1:0] - b_q;
    rem_next   = trial_ge ? trial_diff : trial[DATA_SIZE-1:0];
  end

  always_comb begin
    neg      = a_q[DATA_SIZE-1];
    pos_ovf  = |num_q[Iter-1:DATA_SIZE-1];
    neg_ovf  = (|num_q[Iter-1:DATA_SIZE]) | (num_q[DATA_SIZE-1] & (|num_q[DATA_SIZE-2:0]));
    fix_data = '0;
    fix_user = 2'b00;
    if (b_q == '0) begin
      fix_user = 2'b01;
      if (a_q == '0) begin
        fix_data = '0;
      end else if (neg) begin
        fix_data = MinNeg;
      end else begin
        fix_data = MaxPos;
      end
    end else if (neg) begin
      if (neg_ovf) begin
        fix_data = MinNeg;
        fix_user = 2'b10;
      end else begin
        fix_data = -num_q[DATA_SIZE-1:0];
      end
    end else if (pos_ovf) begin
      fix_data = MaxPos;
      fix_user = 2'b10;
    end else begin
      fix_data = num_q[DATA_SIZE-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= StIdle;
      a_rdy_q  <= 1'b0;
      b_rdy_q  <= 1'b0;
      a_held_q <= 1'b0;
      b_held_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      user_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      num_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (a_take) begin
            a_q      <= div_a_tdata;
            num_q    <= {a_mag, {RES_SHIFT{1'b0}}};
            a_held_q <= 1'b1;
            a_rdy_q  <= 1'b0;
          end else if (!a_held_q) begin
            a_rdy_q <= 1'b1;
          end
          if (b_take) begin
            b_q      <= div_b_tdata;
            b_held_q <= 1'b1;
            b_rdy_q  <= 1'b0;
          end else if (!b_held_q) begin
            b_rdy_q <= 1'b1;
          end
          if (a_take || b_take) begin
            busy_q <= 1'b1;
          end
          if ((a_held_q || a_take) && (b_held_q || b_take)) begin
            state_q <= StCalc;
            a_rdy_q <= 1'b0;
            b_rdy_q <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StCalc: begin
          // Numerator bits shift out the top while quotient bits shift in at the bottom.
          num_q <= {num_q[Iter-2:0], trial_ge};
          rem_q <= rem_next;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(Iter - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          data_q  <= fix_data;
          user_q  <= fix_user;
          valid_q <= 1'b1;
          state_q <= StOut;
        end
        StOut: begin
          if (div_result_tready) begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            a_held_q <= 1'b0;
            b_held_q <= 1'b0;
            a_rdy_q  <= 1'b1;
            b_rdy_q  <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign div_a_tready      = a_rdy_q;
  assign div_b_tready      = b_rdy_q;
  assign div_result_tdata  = data_q;
  assign div_result_tuser  = user_q;
  assign div_result_tvalid = valid_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_pls_fixed_divider.sv
// Directed bench for pls_fixed_divider; expected results queued at drive time, checked on handshake.
module tb_pls_fixed_divider;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] div_a_tdata, div_b_tdata, div_result_tdata;
  logic        div_a_tvalid, div_a_tready, div_b_tvalid, div_b_tready;
  logic [1:0]  div_result_tuser;
  logic        div_result_tvalid, div_result_tready, busy;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  user;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  pls_fixed_divider #(.DATA_SIZE(32), .RES_SHIFT(16)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .div_a_tdata       (div_a_tdata),
    .div_a_tvalid      (div_a_tvalid),
    .div_a_tready      (div_a_tready),
    .div_b_tdata       (div_b_tdata),
    .div_b_tvalid      (div_b_tvalid),
    .div_b_tready      (div_b_tready),
    .div_result_tdata  (div_result_tdata),
    .div_result_tuser  (div_result_tuser),
    .div_result_tvalid (div_result_tvalid),
    .div_result_tready (div_result_tready),
    .busy              (busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result handshake pops the oldest expectation.
  always @(negedge aclk) begin
    if (!areset && div_result_tvalid && div_result_tready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL unexpected_result: observed %h/%b expected none", div_result_tdata,
               div_result_tuser);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        assert ({div_result_tdata, div_result_tuser} === {e.data, e.user}) else begin
          n_fail++;
          $error("FAIL result: observed %h/%b expected %h/%b", div_result_tdata,
                 div_result_tuser, e.data, e.user);
        end
      end
    end
  end

  // Offer the enabled operands; k returns the cycle of the last operand handshake.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic en_a,
                      input logic en_b, output int k);
    logic ha, hb;
    @(posedge aclk);
    #1;
    if (en_a) begin div_a_tdata = a; div_a_tvalid = 1'b1; end
    if (en_b) begin div_b_tdata = b; div_b_tvalid = 1'b1; end
    k = -1;
    for (int t = 0; t < 100 && (div_a_tvalid || div_b_tvalid); t++) begin
      @(negedge aclk);
      ha = div_a_tvalid && div_a_tready;
      hb = div_b_tvalid && div_b_tready;
      if (ha || hb) k = cyc;
      @(posedge aclk);
      #1;
      if (ha) div_a_tvalid = 1'b0;
      if (hb) div_b_tvalid = 1'b0;
    end
    check("operand_handshake", {62'd0, div_a_tvalid, div_b_tvalid}, 64'd0);
    div_a_tvalid = 1'b0;
    div_b_tvalid = 1'b0;
  endtask

  task automatic wait_result(input int k, input string tag);
    int lat;
    lat = -1;
    for (int t = 0; t < 120; t++) begin
      @(negedge aclk);
      if (div_result_tvalid) begin
        lat = cyc - k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd50);
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 20; t++) begin
      @(negedge aclk);
      if (!busy) break;
    end
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                        input logic [1:0] eu, input string tag);
    int k;
    exp_q.push_back({ed, eu});
    send(a, b, 1'b1, 1'b1, k);
    wait_result(k, tag);
    wait_idle(tag);
  endtask

  initial begin
    int k, k2;
    areset = 1'b1;
    div_a_tdata = '0;
    div_b_tdata = '0;
    div_a_tvalid = 1'b0;
    div_b_tvalid = 1'b0;
    div_result_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_a_tready", {63'd0, div_a_tready}, 64'd0);
    check("rst_b_tready", {63'd0, div_b_tready}, 64'd0);
    check("rst_tvalid", {63'd0, div_result_tvalid}, 64'd0);
    check("rst_tdata_tuser", {30'd0, div_result_tdata, div_result_tuser}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;

    run_op(32'd1000, 32'd4, 32'h00FA0000, 2'b00, "pos");
    run_op(-32'sd7, 32'd2, 32'hFFFC8000, 2'b00, "neg_half");
    run_op(32'd1, 32'd3, 32'h00005555, 2'b00, "third");
    run_op(-32'sd1, 32'd3, 32'hFFFFAAAB, 2'b00, "neg_third");

    // Divisor first, then the dividend after a gap.
    exp_q.push_back({32'h7FFFFFFF, 2'b10});
    send(32'd0, 32'd1, 1'b0, 1'b1, k);
    @(negedge aclk);
    check("b_first_state", {61'd0, busy, div_a_tready, div_b_tready}, 64'b110);
    repeat (5) @(posedge aclk);
    send(32'h00010000, 32'd0, 1'b1, 1'b0, k);
    wait_result(k, "b_first");
    wait_idle("b_first");

    run_op(32'h80000000, 32'd1, 32'h80000000, 2'b10, "min_sat");
    run_op(32'hFFFF8000, 32'd1, 32'h80000000, 2'b00, "min_exact");
    run_op(32'd5, 32'd0, 32'h7FFFFFFF, 2'b01, "dz_pos");
    run_op(-32'sd5, 32'd0, 32'h80000000, 2'b01, "dz_neg");
    run_op(32'd0, 32'd0, 32'h00000000, 2'b01, "dz_zero");

    // Backpressure with new operands pending.
    div_result_tready = 1'b0;
    exp_q.push_back({32'h00140000, 2'b00});
    send(32'd100, 32'd5, 1'b1, 1'b1, k);
    wait_result(k, "bp");
    @(posedge aclk);
    #1;
    exp_q.push_back({32'h00030000, 2'b00});
    div_a_tdata = 32'd9;
    div_b_tdata = 32'd3;
    div_a_tvalid = 1'b1;
    div_b_tvalid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge aclk);
      check("bp_hold", {div_result_tvalid, div_a_tready, div_b_tready, busy, div_result_tdata,
                        div_result_tuser}, {1'b1, 1'b0, 1'b0, 1'b1, 32'h00140000, 2'b00});
    end
    @(posedge aclk);
    #1 div_result_tready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("bp_release", {61'd0, div_result_tvalid, div_a_tready, div_b_tready}, 64'b011);
    k2 = cyc;
    @(posedge aclk);
    #1;
    div_a_tvalid = 1'b0;
    div_b_tvalid = 1'b0;
    wait_result(k2, "bp_pending");
    wait_idle("bp_pending");

    // Abort at iteration 10; the aborted operation must never produce a result.
    send(32'd100, 32'd7, 1'b1, 1'b1, k);
    repeat (10) @(posedge aclk);
    #1 areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("abort_state", {62'd0, div_result_tvalid, busy}, 64'd0);
    run_op(32'd12, 32'd3, 32'h00040000, 2'b00, "after_abort");
    repeat (60) @(negedge aclk);
    check("drain", {31'd0, div_result_tvalid, 32'(exp_q.size())}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
